// File: rtl/riscv_pkg.sv
// Shared types for the core debug trace reader.
// Holds the captured record layout and the sweep FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic            err;
    } trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PUSH,
        ST_DONE
    } trace_state_e;

endpackage

// File: rtl/core_trace_reader_if.sv
// Record stream between the trace reader and its sink.
// The master side drives valid and the record; the sink drives ready.
interface core_trace_reader_if;
    import riscv_pkg::*;

    logic       m_valid_o;
    logic       m_ready_i;
    trace_rec_t m_rec_o;

    modport master (output m_valid_o, output m_rec_o, input m_ready_i);
    modport slave  (input m_valid_o, input m_rec_o, output m_ready_i);
endinterface

// File: rtl/core_trace_reader_fifo.sv
// First-word-fall-through record buffer.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module trace_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = trace_rec_t
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/core_trace_reader.sv
// Sweeps a word-aligned window over the core debug read port and
// streams one {pc, addr, data, err} record per word through a FIFO.
module core_trace_reader
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [XLEN-1:0]  base_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [XLEN-1:0]  addr_o,
    input  logic             update_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic [XLEN-1:0]  pc_i,
    core_trace_reader_if.master m,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    trace_state_e     state, state_d;
    logic [XLEN-1:0]  addr_q;
    logic [CNT_W-1:0] remaining;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] err_cnt;
    trace_rec_t       rec_q;
    trace_rec_t       head;
    logic             full, empty, pop;
    logic             push, accept, cap_ok, cap_err, timeout_hit;

    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
    assign pop         = !empty && m.m_ready_i;
    assign accept      = push && (!full || pop);
    assign addr_o      = addr_q;
    assign err_cnt_o   = err_cnt;
    assign m.m_valid_o = !empty;
    assign m.m_rec_o   = head;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        push    = 1'b0;
        cap_ok  = 1'b0;
        cap_err = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) state_d = (count_i != '0) ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: begin
                busy_o  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                if (update_i) begin
                    cap_ok  = 1'b1;
                    state_d = ST_PUSH;
                end else if (timeout_hit) begin
                    cap_err = 1'b1;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                busy_o = 1'b1;
                push   = 1'b1;
                if (accept) begin
                    state_d = (remaining == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q    <= '0;
            remaining <= '0;
            timer     <= '0;
            err_cnt   <= '0;
            rec_q     <= '0;
        end else begin
            if (state == ST_IDLE && start_i) begin
                err_cnt <= '0;
                if (count_i != '0) begin
                    addr_q    <= {base_i[XLEN-1:2], 2'b00};
                    remaining <= count_i;
                end
            end
            if (state == ST_ISSUE) timer <= '0;
            if (state == ST_WAIT && !update_i && !timeout_hit) begin
                timer <= timer + TW'(1);
            end
            if (cap_ok) begin
                rec_q <= '{pc: pc_i, addr: addr_q, data: data_i, err: 1'b0};
            end
            if (cap_err) begin
                rec_q <= '{pc: pc_i, addr: addr_q, data: '0, err: 1'b1};
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
            // Address wraps silently past the top of the space.
            if (accept) begin
                remaining <= remaining - CNT_W'(1);
                addr_q    <= addr_q + XLEN'(4);
            end
        end
    end

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (accept),
        .wdata  (rec_q),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

endmodule
